piece_draw_engine: RTL and testbench



---
 rtl/connect4_draw_pkg.sv | 27 ++
 rtl/cell_pixel_counter.sv | 37 +++
 rtl/piece_draw_engine.sv | 154 +++++++++++++++
 tb/tb_piece_draw_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_draw_pkg.sv
// Shared definitions for the Connect-4 draw path.
//   - state encodings for the piece draw engine FSM
//   - request kind codes (pointer / piece)
//   - default colours (background, red, yellow)
//   - draw_req_t: a draw request as registered on acceptance
package connect4_draw_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ERASE  = 2'd1;
    localparam logic [1:0] STATE_DRAW   = 2'd2;
    localparam logic [1:0] STATE_FINISH = 2'd3;

    localparam logic KIND_POINTER = 1'b0;
    localparam logic KIND_PIECE   = 1'b1;

    localparam logic [2:0] COLOUR_BG     = 3'b000;
    localparam logic [2:0] COLOUR_RED    = 3'b100;
    localparam logic [2:0] COLOUR_YELLOW = 3'b110;

    typedef struct packed {
        logic       kind;
        logic [2:0] col;
        logic [2:0] row;
        logic [2:0] colour;
    } draw_req_t;

endpackage

// File: rtl/cell_pixel_counter.sv
// Raster pixel counter for one CELL_SIZE x CELL_SIZE square.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - force count to 0 (priority over enable)
//   enable      - advance one pixel; wraps to 0 after the last pixel
//   dx, dy      - current column / row within the square (dx fastest)
//   last        - high while the count sits on the final pixel
module cell_pixel_counter #(
    parameter int CELL_SIZE = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         enable,
    output logic [$clog2(CELL_SIZE)-1:0] dx,
    output logic [$clog2(CELL_SIZE)-1:0] dy,
    output logic                         last
);

    localparam int L = $clog2(CELL_SIZE);
    localparam int W = 2 * L;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign dx   = count[L-1:0];
    assign dy   = count[W-1:L];
    assign last = (count == '1);

endmodule

// File: rtl/piece_draw_engine.sv
// Pixel-emitting stage between the game controller and the VGA adapter.
// Accepts one pointer-move or piece-drop request per valid/ready handshake
// and emits one registered x/y/colour/plot write per cycle over a square.
// A pointer move first erases the previous pointer square in BG_COLOUR.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only while idle)
//   req_kind            - 0 pointer, 1 piece
//   req_col, req_row    - target cell (row ignored for pointers)
//   req_colour          - fill colour
//   x_out, y_out        - pixel coordinates
//   colour_out, plot    - pixel colour and write strobe
//   busy, done, err     - in-progress flag, completion pulse, reject pulse
// Build option: define ROUND_PIECE_EN to leave the four corner pixels of
// piece squares unplotted (timing unchanged).
module piece_draw_engine
    import connect4_draw_pkg::*;
#(
    parameter int         CELL_SIZE = 8,
    parameter int         COLS      = 7,
    parameter int         ROWS      = 6,
    parameter int         BOARD_X0  = 48,
    parameter int         BOARD_Y0  = 40,
    parameter logic [2:0] BG_COLOUR = COLOUR_BG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_kind,
    input  logic [2:0] req_col,
    input  logic [2:0] req_row,
    input  logic [2:0] req_colour,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int L = $clog2(CELL_SIZE);
    localparam int W = 2 * L;

    logic [1:0]   state, state_n;
    draw_req_t    cur, cur_n;
    logic         err_r, err_n;
    logic [2:0]   prev_col;
    logic         prev_ptr_valid;

    logic [L-1:0] dx, dy, dx_n, dy_n;
    logic         last;
    logic [W-1:0] idx_n;
    logic         accept, invalid, mask, plot_n;
    logic [2:0]   col_p;
    logic [15:0]  x_calc, y_calc;

    cell_pixel_counter #(
        .CELL_SIZE(CELL_SIZE)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == STATE_IDLE) || (state == STATE_FINISH)),
        .enable ((state == STATE_ERASE) || (state == STATE_DRAW)),
        .dx     (dx),
        .dy     (dy),
        .last   (last)
    );

    always_comb begin
        accept  = req_valid & req_ready;
        invalid = (int'(req_col) >= COLS) ||
                  ((req_kind == KIND_PIECE) && (int'(req_row) >= ROWS));
        cur_n   = cur;
        err_n   = err_r;
        state_n = state;
        case (state)
            STATE_IDLE: begin
                if (accept) begin
                    cur_n = '{kind: req_kind, col: req_col, row: req_row, colour: req_colour};
                    err_n = invalid;
                    if (invalid)
                        state_n = STATE_FINISH;
                    else if ((req_kind == KIND_POINTER) && prev_ptr_valid && (prev_col != req_col))
                        state_n = STATE_ERASE;
                    else
                        state_n = STATE_DRAW;
                end
            end
            STATE_ERASE:  if (last) state_n = STATE_DRAW;
            STATE_DRAW:   if (last) state_n = STATE_FINISH;
            default:      state_n = STATE_IDLE;
        endcase
    end

    // Outputs are registered from the next-cycle view (next state, next
    // pixel index, next request fields) so the first plot appears in the
    // cycle right after acceptance while the counter stays aligned with
    // the pixel actually on the outputs.
    always_comb begin
        idx_n = ((state == STATE_ERASE) || (state == STATE_DRAW)) ? ({dy, dx} + W'(1)) : '0;
        dx_n  = idx_n[L-1:0];
        dy_n  = idx_n[W-1:L];
        col_p = (state_n == STATE_ERASE) ? prev_col : cur_n.col;
        x_calc = 16'(BOARD_X0 + int'(col_p) * CELL_SIZE + int'(dx_n));
        if ((state_n != STATE_ERASE) && (cur_n.kind == KIND_PIECE))
            y_calc = 16'(BOARD_Y0 + int'(cur_n.row) * CELL_SIZE + int'(dy_n));
        else
            y_calc = 16'(BOARD_Y0 - CELL_SIZE + int'(dy_n));
`ifdef ROUND_PIECE_EN
        mask = (state_n == STATE_DRAW) && (cur_n.kind == KIND_PIECE) &&
               ((dx_n == '0) || (dx_n == '1)) && ((dy_n == '0) || (dy_n == '1));
`else
        mask = 1'b0;
`endif
        plot_n = (state_n == STATE_ERASE) || ((state_n == STATE_DRAW) && !mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= STATE_IDLE;
            cur            <= '0;
            err_r          <= 1'b0;
            prev_col       <= '0;
            prev_ptr_valid <= 1'b0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            plot           <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            colour_out     <= '0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            err_r <= err_n;
            if ((state == STATE_FINISH) && !err_r && (cur.kind == KIND_POINTER)) begin
                prev_col       <= cur.col;
                prev_ptr_valid <= 1'b1;
            end
            req_ready  <= (state_n == STATE_IDLE);
            busy       <= (state_n != STATE_IDLE);
            done       <= (state_n == STATE_FINISH);
            err        <= (state_n == STATE_FINISH) && err_n;
            plot       <= plot_n;
            x_out      <= plot_n ? x_calc[7:0] : '0;
            y_out      <= plot_n ? y_calc[6:0] : '0;
            colour_out <= plot_n ? ((state_n == STATE_ERASE) ? BG_COLOUR : cur_n.colour) : '0;
        end
    end

endmodule

// File: tb/tb_piece_draw_engine.sv
// Self-checking bench for piece_draw_engine: a table of requests, each
// pushing its expected pixel stream into a scoreboard queue that is popped
// as plot strobes appear, plus hand-written reset-abort and held-valid
// sequences.
module tb_piece_draw_engine;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_kind;
    logic [2:0] req_col, req_row, req_colour;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done, err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       kind;
        logic [2:0] col;
        logic [2:0] row;
        logic [2:0] colour;
        int         erase_col;   // -1: no erase expected
        logic       exp_err;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    vec_t vecs[11];
    pix_t sb[$];

    piece_draw_engine #(
        .CELL_SIZE(8), .COLS(7), .ROWS(6), .BOARD_X0(48), .BOARD_Y0(40), .BG_COLOUR(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_col(req_col), .req_row(req_row), .req_colour(req_colour),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_expected(input vec_t v);
        if (v.exp_err) return;
        if (v.erase_col >= 0)
            for (int dy = 0; dy < N; dy++)
                for (int dx = 0; dx < N; dx++)
                    sb.push_back('{x: 48 + v.erase_col * N + dx, y: 32 + dy, c: 0});
        for (int dy = 0; dy < N; dy++)
            for (int dx = 0; dx < N; dx++) begin
`ifdef ROUND_PIECE_EN
                if (v.kind && (dx == 0 || dx == N - 1) && (dy == 0 || dy == N - 1)) continue;
`endif
                sb.push_back('{x: 48 + int'(v.col) * N + dx,
                               y: v.kind ? 40 + int'(v.row) * N + dy : 32 + dy,
                               c: int'(v.colour)});
            end
    endtask

    // Drive one request; returns once it has been accepted at a posedge.
    task automatic send(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", req_ready, 1);
        req_valid  = 1'b1;
        req_kind   = v.kind;
        req_col    = v.col;
        req_row    = v.row;
        req_colour = v.colour;
        push_expected(v);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_col    = 3'($urandom_range(0, 7));
        req_row    = 3'($urandom_range(0, 7));
        req_colour = 3'($urandom_range(0, 7));
        req_kind   = 1'($urandom_range(0, 1));
    endtask

    task automatic pop_compare();
        pix_t p;
        check("plot_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            p = sb.pop_front();
            check("pix_x", x_out, p.x);
            check("pix_y", y_out, p.y);
            check("pix_colour", colour_out, p.c);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int t;
        logic seen;
        lat  = v.exp_err ? 1 : (v.erase_col >= 0 ? 2 * N * N + 1 : N * N + 1);
        send(v);
        seen = 1'b0;
        t = 0;
        while (!seen && t < 300) begin
            @(negedge clk);
            t++;
            if (plot) pop_compare();
            if (done) begin
                seen = 1'b1;
                check({tag, "_latency"}, t, lat);
                check({tag, "_err"}, err, v.exp_err);
                check({tag, "_plot_at_done"}, plot, 0);
                check({tag, "_sb_empty"}, sb.size(), 0);
            end else begin
                check({tag, "_busy"}, busy, 1);
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({tag, "_ready_after"}, req_ready, 1);
        check({tag, "_done_pulse"}, done, 0);
        sb.delete();
    endtask

    initial begin
        vec_t v;
        int t;
        int nplot;

        vecs[0]  = '{kind: 1'b1, col: 3'd2, row: 3'd3, colour: 3'b100, erase_col: -1, exp_err: 1'b0};
        vecs[1]  = '{kind: 1'b0, col: 3'd0, row: 3'd0, colour: 3'b110, erase_col: -1, exp_err: 1'b0};
        vecs[2]  = '{kind: 1'b0, col: 3'd4, row: 3'd0, colour: 3'b110, erase_col:  0, exp_err: 1'b0};
        vecs[3]  = '{kind: 1'b0, col: 3'd4, row: 3'd2, colour: 3'b010, erase_col: -1, exp_err: 1'b0};
        vecs[4]  = '{kind: 1'b1, col: 3'd7, row: 3'd0, colour: 3'b100, erase_col: -1, exp_err: 1'b1};
        vecs[5]  = '{kind: 1'b0, col: 3'd7, row: 3'd0, colour: 3'b100, erase_col: -1, exp_err: 1'b1};
        vecs[6]  = '{kind: 1'b0, col: 3'd5, row: 3'd0, colour: 3'b001, erase_col:  4, exp_err: 1'b0};
        vecs[7]  = '{kind: 1'b1, col: 3'd6, row: 3'd5, colour: 3'b110, erase_col: -1, exp_err: 1'b0};
        vecs[8]  = '{kind: 1'b1, col: 3'd0, row: 3'd6, colour: 3'b100, erase_col: -1, exp_err: 1'b1};
        vecs[9]  = '{kind: 1'b1, col: 3'd0, row: 3'd0, colour: 3'b100, erase_col: -1, exp_err: 1'b0};
        vecs[10] = '{kind: 1'b0, col: 3'd5, row: 3'd7, colour: 3'b111, erase_col: -1, exp_err: 1'b0};

        reset = 1'b1;
        req_valid = 1'b0;
        req_kind = 1'b0;
        req_col = '0;
        req_row = '0;
        req_colour = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_colour", colour_out, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a piece draw, after the 20th plot.
        v = '{kind: 1'b1, col: 3'd1, row: 3'd1, colour: 3'b011, erase_col: -1, exp_err: 1'b0};
        send(v);
        nplot = 0;
        t = 0;
        while (nplot < 20 && t < 100) begin
            @(negedge clk);
            t++;
            if (plot) begin
                pop_compare();
                nplot++;
            end
        end
        check("abort_reached_20", nplot, 20);
        reset = 1'b1;
        @(negedge clk);
        check("abort_plot", plot, 0);
        check("abort_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_plot_hold", plot, 0);

        // prev_ptr_valid was cleared, so a new pointer skips the erase.
        v = '{kind: 1'b0, col: 3'd3, row: 3'd0, colour: 3'b110, erase_col: -1, exp_err: 1'b0};
        run_vec(v, "post_reset_ptr");

        // req_valid held high across done: re-accepted as soon as ready returns.
        @(negedge clk);
        req_valid  = 1'b1;
        req_kind   = 1'b1;
        req_col    = 3'd7;
        req_row    = 3'd0;
        req_colour = 3'b100;
        @(posedge clk);
        @(negedge clk);
        check("held_done1", done, 1);
        check("held_err1", err, 1);
        check("held_ready1", req_ready, 0);
        @(negedge clk);
        check("held_ready2", req_ready, 1);
        check("held_done2_low", done, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("held_done3", done, 1);
        check("held_err3", err, 1);
        @(negedge clk);
        check("held_idle", req_ready, 1);
        check("held_no_plot", plot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
